// File: rtl/flopoco_fcmp_pipe.sv
// Two-stage FloPoCo floating-point comparator with runtime predicate and valid/ready handshake.
// Optional: define FCMP_MINMAX_EN to add MIN/MAX modes (110/111) and the out_minmax port.
module flopoco_fcmp_pipe #(
  parameter int WE    = 4,
  parameter int WF    = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WE+WF+2:0]   X,
  input  logic [WE+WF+2:0]   Y,
  input  logic [2:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               result,
  output logic               unordered,
  output logic [CNT_W-1:0]   unord_cnt,
`ifdef FCMP_MINMAX_EN
  output logic [WE+WF+2:0]   out_minmax,
`endif
  input  logic               cnt_clr
);

  localparam int W  = WE + WF + 3;
  localparam int MW = WE + WF;

  typedef enum logic [2:0] {
    MODE_EQ  = 3'b000,
    MODE_LT  = 3'b001,
    MODE_LE  = 3'b010,
    MODE_GT  = 3'b011,
    MODE_GE  = 3'b100,
    MODE_NE  = 3'b101,
    MODE_MIN = 3'b110,
    MODE_MAX = 3'b111
  } fcmpMode_t;

  typedef struct packed {
    logic zero;
    logic norm;
    logic inf;
    logic nan;
    logic sign;
  } opFlags_t;

  function automatic opFlags_t decode(input logic [W-1:0] v);
    opFlags_t f;
    f.zero = (v[W-1:W-2] == 2'b00);
    f.norm = (v[W-1:W-2] == 2'b01);
    f.inf  = (v[W-1:W-2] == 2'b10);
    f.nan  = (v[W-1:W-2] == 2'b11);
    f.sign = v[W-3];
    return f;
  endfunction

  // Total order of non-NaN classes: -inf, -normal, zero (either sign), +normal, +inf.
  function automatic logic [2:0] rankOf(input opFlags_t f);
    logic [2:0] r;
    if (f.zero || f.nan)     r = 3'd2;
    else if (f.inf)          r = f.sign ? 3'd0 : 3'd4;
    else if (f.norm)         r = f.sign ? 3'd1 : 3'd3;
    else                     r = 3'd2;
    return r;
  endfunction

  logic       r1Valid, r2Valid;
  opFlags_t   r1XF, r1YF;
  logic       r1MagLt, r1MagGt, r1MagEq;
  fcmpMode_t  r1Mode;
  logic       r2Result, r2Unord;
  logic [CNT_W-1:0] r_cnt;
  logic       w_s1Adv, w_s2Adv;
  logic [2:0] w_xRank, w_yRank;
  logic       w_lt, w_eq, w_gt, w_unord, w_res;
`ifdef FCMP_MINMAX_EN
  logic [W-1:0] r1X, r1Y, r2Minmax;
  logic         w_minSelY, w_maxSelY, w_selY;
`endif

  assign w_s2Adv  = ~r2Valid | out_ready;
  assign w_s1Adv  = ~r1Valid | w_s2Adv;
  assign in_ready = w_s1Adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1Valid <= 1'b0;
      r1XF    <= '0;
      r1YF    <= '0;
      r1MagLt <= 1'b0;
      r1MagGt <= 1'b0;
      r1MagEq <= 1'b0;
      r1Mode  <= MODE_EQ;
`ifdef FCMP_MINMAX_EN
      r1X     <= '0;
      r1Y     <= '0;
`endif
    end else if (w_s1Adv) begin
      r1Valid <= in_valid;
      r1XF    <= decode(X);
      r1YF    <= decode(Y);
      r1MagLt <= (X[MW-1:0] <  Y[MW-1:0]);
      r1MagGt <= (X[MW-1:0] >  Y[MW-1:0]);
      r1MagEq <= (X[MW-1:0] == Y[MW-1:0]);
      r1Mode  <= fcmpMode_t'(mode);
`ifdef FCMP_MINMAX_EN
      r1X     <= X;
      r1Y     <= Y;
`endif
    end
  end

  assign w_xRank = rankOf(r1XF);
  assign w_yRank = rankOf(r1YF);
  assign w_unord = r1XF.nan | r1YF.nan;

  // Same-class normals compare by magnitude, reversed when both are negative.
  always_comb begin
    w_lt = 1'b0;
    w_eq = 1'b0;
    if (w_xRank != w_yRank) begin
      w_lt = (w_xRank < w_yRank);
    end else if (w_xRank == 3'd1) begin
      w_lt = r1MagGt;
      w_eq = r1MagEq;
    end else if (w_xRank == 3'd3) begin
      w_lt = r1MagLt;
      w_eq = r1MagEq;
    end else begin
      w_eq = 1'b1;
    end
  end

  assign w_gt = ~w_lt & ~w_eq;

`ifdef FCMP_MINMAX_EN
  always_comb begin
    w_minSelY = 1'b0;
    w_maxSelY = 1'b0;
    if (r1XF.nan) begin
      w_minSelY = ~r1YF.nan;
      w_maxSelY = ~r1YF.nan;
    end else if (r1YF.nan) begin
      w_minSelY = 1'b0;
      w_maxSelY = 1'b0;
    end else if (r1XF.zero && r1YF.zero) begin
      w_minSelY = ~r1XF.sign & r1YF.sign;
      w_maxSelY = r1XF.sign & ~r1YF.sign;
    end else begin
      w_minSelY = w_gt;
      w_maxSelY = w_lt;
    end
  end
`endif

  always_comb begin
    w_res = 1'b0;
`ifdef FCMP_MINMAX_EN
    w_selY = 1'b0;
`endif
    case (r1Mode)
      MODE_EQ: w_res = w_eq & ~w_unord;
      MODE_LT: w_res = w_lt & ~w_unord;
      MODE_LE: w_res = (w_lt | w_eq) & ~w_unord;
      MODE_GT: w_res = w_gt & ~w_unord;
      MODE_GE: w_res = (w_gt | w_eq) & ~w_unord;
      MODE_NE: w_res = ~w_eq | w_unord;
`ifdef FCMP_MINMAX_EN
      MODE_MIN: begin
        w_selY = w_minSelY;
        w_res  = w_minSelY;
      end
      MODE_MAX: begin
        w_selY = w_maxSelY;
        w_res  = w_maxSelY;
      end
`endif
      default: w_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2Valid  <= 1'b0;
      r2Result <= 1'b0;
      r2Unord  <= 1'b0;
`ifdef FCMP_MINMAX_EN
      r2Minmax <= '0;
`endif
    end else if (w_s2Adv) begin
      r2Valid  <= r1Valid;
      r2Result <= w_res;
      r2Unord  <= w_unord;
`ifdef FCMP_MINMAX_EN
      r2Minmax <= w_selY ? r1Y : r1X;
`endif
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r2Valid && out_ready && r2Unord && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r2Valid;
  assign result    = r2Result;
  assign unordered = r2Unord;
  assign unord_cnt = r_cnt;
`ifdef FCMP_MINMAX_EN
  assign out_minmax = r2Minmax;
`endif

endmodule

// File: doc/flopoco_fcmp_pipe.md
Name: flopoco_fcmp_pipe

Overview:
Parametrised, pipelined FloPoCo-format floating-point comparator with a runtime-selectable predicate (EQ/LT/LE/GT/GE/NE) and a valid/ready handshake on both sides. It generalises the fixed-width combinational less-than comparator used by the HLS datapath. It is the compare/select core that scheduled dataflow (ReLU, max-pool, argmax) instantiates. It also keeps a saturating count of unordered (NaN) comparisons for debug readback.

Parameters:
- WE, 4, exponent width (>=2)
- WF, 4, fraction width (>=1)
- CNT_W, 16, width of unordered-event counter
- Derived: W = WE+WF+3 (operand width)
- Operand format: [W-1:W-2] exc (00 zero, 01 normal, 10 inf, 11 NaN), [W-3] sign, [W-4:0] exp||frac

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept the pair this cycle
- X  in  W  operand X
- Y  in  W  operand Y
- mode  in  3  predicate: 000 EQ, 001 LT, 010 LE, 011 GT, 100 GE, 101 NE, 11x reserved
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  1  predicate(X,Y)
- unordered  out  1  X or Y is NaN
- unord_cnt  out  CNT_W  saturating count of accepted unordered results
- cnt_clr  in  1  synchronous clear of unord_cnt

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high. While rst is asserted, both stage-valid registers, out_valid, result, unordered and unord_cnt are 0 (and out_minmax when that port is compiled in).
- Pipeline: 2 register stages; latency 2 cycles from input handshake to out_valid when no stall occurs.
  - S1 registers decode flags (zero/normal/inf/NaN per operand, signs), unsigned expfrac lt/gt/eq, and mode.
  - S2 registers result and unordered.
- Handshake: a transfer occurs when valid&&ready on a side.
  - S2 advances if it is empty or out_ready=1. S1 advances if it is empty or S2 advances.
  - in_ready = ~s1_valid | s2_adv. This is combinational from out_ready; there is no skid buffer. Full throughput is 1 pair/cycle.
  - Stalled stages hold data stably. out_valid and result must not change while out_valid&&!out_ready.
- Ordering rules for non-NaN values:
  - -inf < negative normals < zeros < positive normals < +inf.
  - +0 == -0, regardless of the sign bit.
  - Normals with equal sign are ordered by unsigned expfrac; the ordering is reversed when both are negative.
  - Equal-signed infinities are equal.
- Unordered: if X or Y is NaN, unordered=1; EQ/LT/LE/GT/GE give 0 and NE gives 1.
- Reserved modes give result=0. unordered is still reported.
- Counter:
  - unord_cnt increments by 1 on each output transfer (out_valid&&out_ready) with unordered=1.
  - It saturates at all-ones; there is no wrap.
  - cnt_clr has priority over the increment in the same cycle.
- Reset mid-operation: in-flight pairs are discarded, and no output handshake occurs for them.

Optional Feature:
- Macro: FCMP_MINMAX_EN.
- When defined:
  - Adds output out_minmax (W bits), carried through both stages with the result.
  - mode 110 = MIN and mode 111 = MAX select the smaller/larger operand. Their result bit is 1 iff Y was selected.
  - If exactly one operand is NaN, the non-NaN operand is selected. If both are NaN, X is selected.
  - For +0 vs -0, MIN returns -0 and MAX returns +0.
- When undefined: the port is absent and modes 11x are reserved as above.

Test Plan:
- Default WE=4, WF=4 (W=11). Encodings: +1.0=0x270, 2.0=0x280, -1.0=0x370, +0=0x000, -0=0x100, +inf=0x400, -inf=0x500, NaN=0x600.
- LT X=0x270, Y=0x280, out_ready=1 -> out_valid in cycle 2 after accept, result=1, unordered=0. Swap operands -> result=0.
- Negative normals: GT X=0x370, Y=0x380 (-2.0) -> result=1. EQ X=0x000, Y=0x100 -> result=1. LT X=0x500, Y=0x370 -> result=1.
- NaN: X=0x600, Y=0x270 run through all 6 modes -> result=0 except NE=1, unordered=1. unord_cnt=6 after the outputs drain. Pulse cnt_clr in the same cycle as a 7th NaN transfer -> unord_cnt=0.
- Backpressure: stream 8 back-to-back pairs with out_ready low for 3 cycles mid-stream.
  - in_ready drops once both stages are full.
  - No result is lost or duplicated; outputs come out in order.
  - result is held stable while stalled.
- Reset: assert rst asynchronously with both stages full -> out_valid=0 and unord_cnt=0 immediately. After release, the first new pair emerges with latency 2.
- FCMP_MINMAX_EN:
  - MIN X=0x000, Y=0x100 -> out_minmax=0x100, result=1.
  - MAX X=0x600, Y=0x280 -> out_minmax=0x280.
